// File: rtl/i2c_op_master_if.sv
// Op-feed handshake plus open-drain SCL/SDA controls shared by the I2C op master and its surroundings.
interface i2c_op_master_if;
  logic       Start;
  logic [1:0] Op;
  logic [7:0] Data;
  logic       Update;
  logic       SDA_i;
  logic       SCL_oe;
  logic       SDA_oe;
  logic       Busy;
  logic       Done;
  logic       Nack;

  modport master (
    input  Start, Op, Data, SDA_i,
    output Update, SCL_oe, SDA_oe, Busy, Done, Nack
  );

  modport slave (
    output Start, Op, Data, SDA_i,
    input  Update, SCL_oe, SDA_oe, Busy, Done, Nack
  );
endinterface

// File: rtl/i2c_op_master.sv
// Write-only bit-level I2C master executing the {Op,Data} entry stream of the init-sequence feed.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | bus released, waiting for Start
// S_FETCH   | 2 clks for the feed to present the next entry
// S_DECODE  | latch Op/Data, choose START/BIT/STOP path
// S_RSTART  | one released-SCL quarter ahead of a repeated start
// S_START_C | start condition: 2 quarters released, 2 quarters SDA low
// S_BIT     | 8 data bits MSB first, 4 quarters each
// S_ACK     | ninth clock, SDA released, slave ACK sampled in q2
// S_STOP_C  | stop condition over 5 quarters
// S_END     | Done pulse, drop Busy
module i2c_op_master #(
  parameter int CLK_DIV = 125
) (
  input  logic            Clk,
  input  logic            Reset_n,
  i2c_op_master_if.master bus
);

  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TC_LOAD = TW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_RSTART, S_START_C,
    S_BIT, S_ACK, S_STOP_C, S_END
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   tmr, tmr_n;
  logic [2:0]      qidx, qidx_n;
  logic [2:0]      bidx, bidx_n;
  logic            fcnt, fcnt_n;
  logic [7:0]      sr, sr_n;
  logic            in_txn, in_txn_n;
  logic            rpend, rpend_n;
  logic            ack_smp, ack_n;
  logic            update_r, update_n;
  logic            done_r, done_n;
  logic            busy_r, busy_n;
  logic            nack_r, nack_n;
  logic            scl_r, sda_r;
  logic [1:0]      drv_n;
  logic            timed, tc;

  // {scl_oe, sda_oe} for a given state/quarter; evaluated on the next state so the pins are registered
  function automatic logic [1:0] line_drive(input state_t st, input logic [2:0] q, input logic b);
    logic [1:0] d;
    d = 2'b00;
    case (st)
      S_START_C: d = {1'b0, q[1]};
      S_BIT:     d = {~q[1], ~b};
      S_ACK:     d = {~q[1], 1'b0};
      S_STOP_C:  d = {(q == 3'd0), (q < 3'd3)};
      default:   d = 2'b00;
    endcase
    return d;
  endfunction

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      tmr      <= TC_LOAD;
      qidx     <= '0;
      bidx     <= '0;
      fcnt     <= 1'b0;
      sr       <= '0;
      in_txn   <= 1'b0;
      rpend    <= 1'b0;
      ack_smp  <= 1'b0;
      update_r <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      nack_r   <= 1'b0;
      scl_r    <= 1'b0;
      sda_r    <= 1'b0;
    end else begin
      state    <= state_n;
      tmr      <= tmr_n;
      qidx     <= qidx_n;
      bidx     <= bidx_n;
      fcnt     <= fcnt_n;
      sr       <= sr_n;
      in_txn   <= in_txn_n;
      rpend    <= rpend_n;
      ack_smp  <= ack_n;
      update_r <= update_n;
      done_r   <= done_n;
      busy_r   <= busy_n;
      nack_r   <= nack_n;
      scl_r    <= drv_n[1];
      sda_r    <= drv_n[0];
    end
  end

  always_comb begin
    state_n  = state;
    qidx_n   = qidx;
    bidx_n   = bidx;
    fcnt_n   = 1'b0;
    sr_n     = sr;
    in_txn_n = in_txn;
    rpend_n  = rpend;
    ack_n    = ack_smp;
    update_n = 1'b0;
    done_n   = 1'b0;
    busy_n   = busy_r;
    nack_n   = nack_r;
    timed    = (state == S_RSTART) || (state == S_START_C) || (state == S_BIT) ||
               (state == S_ACK) || (state == S_STOP_C);
    tc       = (tmr == '0);
    tmr_n    = (timed && !tc) ? tmr - TW'(1) : TC_LOAD;

    case (state)
      S_IDLE: begin
        if (bus.Start) begin
          busy_n   = 1'b1;
          nack_n   = 1'b0;
          update_n = 1'b1;
          state_n  = S_FETCH;
        end
      end
      S_FETCH: begin
        fcnt_n = 1'b1;
        if (fcnt) begin
          fcnt_n  = 1'b0;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        sr_n   = bus.Data;
        qidx_n = '0;
        bidx_n = 3'd7;
        case (bus.Op)
          2'd1: state_n = in_txn ? S_RSTART : S_START_C;
          2'd2: state_n = in_txn ? S_BIT : S_START_C;
          2'd3: begin
            rpend_n = 1'b1;
            state_n = in_txn ? S_STOP_C : S_START_C;
          end
          default: begin
            rpend_n = 1'b0;
            state_n = in_txn ? S_STOP_C : S_END;
          end
        endcase
      end
      S_RSTART: begin
        if (tc) state_n = S_START_C;
      end
      S_START_C: begin
        if (tc) begin
          if (qidx == 3'd3) begin
            qidx_n   = '0;
            bidx_n   = 3'd7;
            in_txn_n = 1'b1;
            state_n  = S_BIT;
          end else begin
            qidx_n = qidx + 3'd1;
          end
        end
      end
      S_BIT: begin
        if (tc) begin
          if (qidx == 3'd3) begin
            qidx_n = '0;
            if (bidx == 3'd0) state_n = S_ACK;
            else              bidx_n  = bidx - 3'd1;
          end else begin
            qidx_n = qidx + 3'd1;
          end
        end
      end
      S_ACK: begin
        if (tc) begin
          if (qidx == 3'd3) begin
            qidx_n = '0;
            if (ack_smp) begin
              nack_n  = 1'b1;
              rpend_n = 1'b0;
              state_n = S_STOP_C;
            end else begin
              update_n = 1'b1;
              state_n  = S_FETCH;
            end
          end else begin
            // SCL has been released for a full quarter by the end of q2
            if (qidx == 3'd2) ack_n = bus.SDA_i;
            qidx_n = qidx + 3'd1;
          end
        end
      end
      S_STOP_C: begin
        if (tc) begin
          if (qidx == 3'd4) begin
            qidx_n   = '0;
            in_txn_n = 1'b0;
            state_n  = rpend ? S_START_C : S_END;
          end else begin
            qidx_n = qidx + 3'd1;
          end
        end
      end
      S_END: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    drv_n = line_drive(state_n, qidx_n, sr_n[bidx_n]);
  end

  assign bus.Update = update_r;
  assign bus.Done   = done_r;
  assign bus.Busy   = busy_r;
  assign bus.Nack   = nack_r;
  assign bus.SCL_oe = scl_r;
  assign bus.SDA_oe = sda_r;

endmodule
